// File: rtl/one_to_three.sv
// Triple-redundant frame transmitter: buffers one input frame, then replays it three times
// with copy IDs 1..3 in the ID byte. Optional ONE2THREE_INJECT_ERR_EN adds inject_err to corrupt copy 2.
module one_to_three #(
   parameter int ID_OFFSET = 34,
   parameter int ADDR_W    = 12,
   parameter int GAP       = 12
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data_in,
   input  logic       en_in,
`ifdef ONE2THREE_INJECT_ERR_EN
   input  logic       inject_err,
`endif
   output logic [7:0] data_out,
   output logic       en_out,
   output logic       ready,
   output logic       drop
);

   localparam int              DEPTH_INT = 1 << ADDR_W;
   localparam logic [ADDR_W:0] DEPTH     = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ID_POS    = (ADDR_W+1)'(ID_OFFSET);
   localparam logic [7:0]      GAP_LAST  = 8'(GAP - 2);

   typedef enum logic [2:0] {
      S_IDLE, S_CAPTURE, S_DISCARD, S_PRIME, S_SEND, S_GAP
   } state_t;

   state_t            state, state_n;
   logic [ADDR_W:0]   wr_cnt, wr_cnt_n;
   logic [ADDR_W:0]   len, len_n;
   logic [ADDR_W:0]   out_idx, out_idx_n;
   logic [ADDR_W-1:0] rd_addr, rd_addr_n;
   logic [1:0]        copy, copy_n;
   logic [7:0]        gap_cnt, gap_cnt_n;
   logic [7:0]        data_out_n;
   logic              en_out_n, ready_n, drop_n;
   logic              inj_flag, inj_flag_n;
   logic              en_in_prev;
   logic              rising, last_byte, inject_sample;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [7:0]        wdata;
   logic [7:0]        rd_data;
   logic [7:0]        tx_byte;
   logic [7:0]        mem [0:DEPTH_INT-1];

`ifdef ONE2THREE_INJECT_ERR_EN
   assign inject_sample = inject_err;
`else
   assign inject_sample = 1'b0;
`endif

   // Only a fresh en_in edge may start a frame, so a tail of an ignored frame is never captured
   assign rising    = en_in & ~en_in_prev;
   assign last_byte = (out_idx == len - 1'b1);

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
      rd_data <= mem[rd_addr];
   end

   always_comb begin
      tx_byte = rd_data;
      if (out_idx == ID_POS)
         tx_byte[3:0] = {2'b00, copy};
      if (inj_flag && copy == 2'd2 && last_byte)
         tx_byte = ~tx_byte;
   end

   always_comb begin
      state_n    = state;
      wr_cnt_n   = wr_cnt;
      len_n      = len;
      out_idx_n  = out_idx;
      rd_addr_n  = rd_addr;
      copy_n     = copy;
      gap_cnt_n  = gap_cnt;
      inj_flag_n = inj_flag;
      ready_n    = ready;
      data_out_n = 8'h00;
      en_out_n   = 1'b0;
      drop_n     = 1'b0;
      we         = 1'b0;
      waddr      = wr_cnt[ADDR_W-1:0];
      wdata      = data_in;

      if (rising && !(state == S_IDLE && ready))
         drop_n = 1'b1;

      case (state)
         S_IDLE: begin
            // ready is 0 here for one cycle after the final copy, so it rises after the last byte
            if (!ready)
               ready_n = 1'b1;
            else if (rising) begin
               we         = 1'b1;
               waddr      = '0;
               wr_cnt_n   = {{ADDR_W{1'b0}}, 1'b1};
               ready_n    = 1'b0;
               inj_flag_n = inject_sample;
               state_n    = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            if (en_in) begin
               if (wr_cnt == DEPTH)
                  state_n = S_DISCARD;
               else begin
                  we       = 1'b1;
                  wr_cnt_n = wr_cnt + 1'b1;
               end
            end else begin
               len_n = wr_cnt;
               if (wr_cnt <= ID_POS) begin
                  drop_n  = 1'b1;
                  ready_n = 1'b1;
                  state_n = S_IDLE;
               end else begin
                  copy_n    = 2'd1;
                  rd_addr_n = '0;
                  state_n   = S_PRIME;
               end
            end
         end
         S_DISCARD: begin
            if (!en_in) begin
               drop_n  = 1'b1;
               ready_n = 1'b1;
               state_n = S_IDLE;
            end
         end
         S_PRIME: begin
            rd_addr_n = rd_addr + 1'b1;
            out_idx_n = '0;
            state_n   = S_SEND;
         end
         S_SEND: begin
            en_out_n   = 1'b1;
            data_out_n = tx_byte;
            rd_addr_n  = rd_addr + 1'b1;
            out_idx_n  = out_idx + 1'b1;
            if (last_byte) begin
               rd_addr_n = '0;
               out_idx_n = '0;
               if (copy == 2'd3)
                  state_n = S_IDLE;
               else begin
                  copy_n    = copy + 1'b1;
                  gap_cnt_n = '0;
                  // PRIME is the final idle cycle, so a one-cycle gap skips the GAP state
                  state_n   = (GAP == 1) ? S_PRIME : S_GAP;
               end
            end
         end
         S_GAP: begin
            gap_cnt_n = gap_cnt + 1'b1;
            if (gap_cnt == GAP_LAST)
               state_n = S_PRIME;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         wr_cnt     <= '0;
         len        <= '0;
         out_idx    <= '0;
         rd_addr    <= '0;
         copy       <= '0;
         gap_cnt    <= '0;
         inj_flag   <= 1'b0;
         en_in_prev <= 1'b0;
         data_out   <= 8'h00;
         en_out     <= 1'b0;
         ready      <= 1'b1;
         drop       <= 1'b0;
      end else begin
         state      <= state_n;
         wr_cnt     <= wr_cnt_n;
         len        <= len_n;
         out_idx    <= out_idx_n;
         rd_addr    <= rd_addr_n;
         copy       <= copy_n;
         gap_cnt    <= gap_cnt_n;
         inj_flag   <= inj_flag_n;
         en_in_prev <= en_in;
         data_out   <= data_out_n;
         en_out     <= en_out_n;
         ready      <= ready_n;
         drop       <= drop_n;
      end
   end

endmodule

// File: tb/tb_one_to_three.sv
// Directed bench for one_to_three: replay timing, ID nibbles, short/oversize drops,
// collisions during transmit, mid-transmit reset, and optional error injection.
module tb_one_to_three;

   localparam int GAP = 12;

   logic       clk;
   logic       rst;
   logic [7:0] data_in;
   logic       en_in;
   logic [7:0] data_out;
   logic       en_out;
   logic       ready;
   logic       drop;
`ifdef ONE2THREE_INJECT_ERR_EN
   logic       inject_err;
`endif

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int fall;
   int b_start;
   int drop_cnt;
   int drop_cyc;
   int ready_rise;
   logic ready_q;
   logic [7:0] out_data[$];
   int out_cyc[$];

   one_to_three #(.ID_OFFSET(34), .ADDR_W(12), .GAP(GAP)) dut (
      .clk(clk),
      .rst(rst),
      .data_in(data_in),
      .en_in(en_in),
`ifdef ONE2THREE_INJECT_ERR_EN
      .inject_err(inject_err),
`endif
      .data_out(data_out),
      .en_out(en_out),
      .ready(ready),
      .drop(drop)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Output recorder, sampled on the falling edge
   always @(negedge clk) begin
      if (en_out) begin
         out_data.push_back(data_out);
         out_cyc.push_back(cyc);
      end
      if (drop) begin
         drop_cnt = drop_cnt + 1;
         drop_cyc = cyc;
      end
      if (ready && !ready_q)
         ready_rise = cyc;
      ready_q = ready;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [7:0] pat(input int base, input int i);
      logic [7:0] v;
      v = 8'(i * 7 + base);
      if (i == 34)
         v = 8'hA0;
      return v;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clearRecords();
      out_data.delete();
      out_cyc.delete();
      drop_cnt   = 0;
      drop_cyc   = -1;
      ready_rise = -1;
   endtask

   task automatic waitUntil(input int target);
      while (cyc < target) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input int n, input int base);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         en_in   = 1'b1;
         data_in = pat(base, i);
      end
      @(posedge clk);
      #1;
      en_in   = 1'b0;
      data_in = 8'h00;
      fall    = cyc;
   endtask

   task automatic checkOutput(input int len, input int base, input int f, input bit inv2);
      int n;
      logic [7:0] exp;
      waitUntil(f + 3 + 3 * len + 2 * GAP + 4);
      check("burst_count", out_data.size(), 3 * len);
      n = (out_data.size() < 3 * len) ? out_data.size() : 3 * len;
      for (int idx = 0; idx < n; idx++) begin
         int k;
         int j;
         k = idx / len;
         j = idx % len;
         exp = pat(base, j);
         if (j == 34)
            exp[3:0] = 4'(k + 1);
         if (inv2 && k == 1 && j == len - 1)
            exp = ~exp;
         check($sformatf("byte c%0d i%0d", k + 1, j), out_data[idx], exp);
         check($sformatf("time c%0d i%0d", k + 1, j), out_cyc[idx], f + 3 + k * (len + GAP) + j);
      end
      check("ready_rise", ready_rise, f + 3 + 3 * len + 2 * GAP);
   endtask

   initial begin
      rst     = 1'b1;
      en_in   = 1'b0;
      data_in = 8'h00;
      ready_q = 1'b0;
`ifdef ONE2THREE_INJECT_ERR_EN
      inject_err = 1'b0;
`endif
      clearRecords();
      #2;
      check("rst_data_out", data_out, 0);
      check("rst_en_out", en_out, 0);
      check("rst_ready", ready, 1);
      check("rst_drop", drop, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      $display("[TB] 60-byte frame");
      clearRecords();
      applyStimulus(60, 3);
      check("capture_ready", ready, 0);
      checkOutput(60, 3, fall, 1'b0);
      check("t1_drops", drop_cnt, 0);

      $display("[TB] 20-byte frame");
      clearRecords();
      applyStimulus(20, 1);
      waitUntil(fall + 1);
      check("short_ready", ready, 1);
      waitUntil(fall + 20);
      check("short_drop_cnt", drop_cnt, 1);
      check("short_drop_cyc", drop_cyc, fall + 1);
      check("short_no_out", out_data.size(), 0);

      $display("[TB] 4097-byte frame");
      clearRecords();
      applyStimulus(4097, 2);
      check("ovf_no_drop_yet", drop_cnt, 0);
      waitUntil(fall + 20);
      check("ovf_drop_cnt", drop_cnt, 1);
      check("ovf_drop_cyc", drop_cyc, fall + 1);
      check("ovf_no_out", out_data.size(), 0);
      check("ovf_ready", ready, 1);

      $display("[TB] frame arriving during copy 2");
      clearRecords();
      applyStimulus(60, 5);
      waitUntil(fall + 3 + 72 + 5);
      b_start = cyc;
      en_in   = 1'b1;
      data_in = 8'h55;
      repeat (9) begin
         @(posedge clk);
         #1;
         data_in = data_in + 8'h01;
      end
      @(posedge clk);
      #1;
      en_in = 1'b0;
      checkOutput(60, 5, fall, 1'b0);
      check("coll_drop_cnt", drop_cnt, 1);
      check("coll_drop_cyc", drop_cyc, b_start + 1);

      $display("[TB] reset during copy 1");
      clearRecords();
      applyStimulus(60, 9);
      waitUntil(fall + 13);
      check("pre_rst_en_out", en_out, 1);
      check("pre_rst_byte10", data_out, pat(9, 10));
      rst = 1'b1;
      #1;
      check("rst_async_en_out", en_out, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_ready", ready, 1);
      check("post_rst_en_out", en_out, 0);
      clearRecords();
      applyStimulus(60, 11);
      checkOutput(60, 11, fall, 1'b0);

`ifdef ONE2THREE_INJECT_ERR_EN
      $display("[TB] error injection on copy 2");
      clearRecords();
      inject_err = 1'b1;
      applyStimulus(60, 13);
      inject_err = 1'b0;
      checkOutput(60, 13, fall, 1'b1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/one_to_three.md
# one_to_three

Triple-redundant frame transmitter for the Ethernet path, paired with the redundant receiver/voter on the far end. It captures one outgoing frame byte stream into an internal buffer. It then replays the frame three times back-to-back, writing copy ID 1, 2, 3 into the low nibble of the byte at the ID offset, with a fixed idle gap between copies. It sits between the frame builder and the MAC/PHY byte interface.

## Interface
- ID_OFFSET, 34 — byte index (0 = first byte with en_in high) whose low nibble carries the copy ID.
- ADDR_W, 12 — buffer address width; maximum frame length 2^ADDR_W bytes.
- GAP, 12 — idle cycles (en_out low) between consecutive copies; legal range 1..255.
- clk  in  1  byte clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  8  frame byte, valid when en_in high.
- en_in  in  1  frame enable; one byte per cycle, contiguous, high for the whole frame.
- data_out  out  8  transmitted byte, valid when en_out high.
- en_out  out  1  transmit enable; high for exactly frame-length cycles per copy.
- ready  out  1  high when a new frame may start on en_in.
- drop  out  1  one-cycle pulse when an input frame is discarded.

## Operation
- Reset (async): state IDLE. data_out=0, en_out=0, ready=1, drop=0. All counters 0.
- States: IDLE, CAPTURE, DISCARD, PRIME, SEND, GAP.
- IDLE: en_in=1 writes byte 0 to buffer address 0, sets wr_addr=1, ready<=0, goes to CAPTURE.
- CAPTURE: while en_in=1, write data_in at wr_addr and increment wr_addr.
  - On en_in=0: len=wr_addr.
    - If len <= ID_OFFSET: pulse drop, go to IDLE with ready<=1.
    - Otherwise: copy=1, rd_addr=0, go to PRIME.
  - If en_in is still 1 when wr_addr would wrap past 2^ADDR_W-1: go to DISCARD.
- DISCARD: wait for en_in=0, then pulse drop, go to IDLE with ready<=1. Nothing is transmitted.
- PRIME: one cycle to cover the synchronous-read latency of the buffer. Goes to SEND.
- SEND: output one byte per cycle from the buffer.
  - At byte index ID_OFFSET, data_out = {stored[7:4], copy[3:0]}. Every other byte passes unchanged.
  - After byte len-1: if copy<3, increment copy, reset rd_addr, go to GAP. If copy=3, go to IDLE with ready<=1.
- GAP: count GAP cycles with en_out=0, then go to PRIME. The PRIME cycle counts as the last GAP cycle, so total idle time is exactly GAP cycles.
- en_in=1 while ready=0 (in PRIME, SEND or GAP): the frame is ignored and drop pulses once on that frame's first byte. The buffer is not disturbed.
- Byte pointers are ADDR_W bits wide. The length counter is ADDR_W+1 bits wide so that the full 2^ADDR_W length is representable.
- UDP checksum must be zero upstream; this block does not recompute checksums.

## Timing
- Buffer: inferred single-clock dual-port RAM, 1-cycle read latency. Outputs are registered.
- First en_out edge: exactly 2 cycles after the first rising edge that samples en_in=0 at frame end.
- Per copy: en_out high exactly len consecutive cycles, then exactly GAP low cycles before the next copy.
- Total occupancy from end of input frame to ready=1: 2 + 3·len + 2·GAP cycles.
- ready rises in the cycle after the last en_out byte of copy 3. A new frame can start the following cycle.
- drop: single-cycle pulse, registered.
- rst asserted mid-SEND or mid-GAP: en_out drops to 0 asynchronously and the frame is abandoned. ready is 1 after release.

## Configuration
- ONE2THREE_INJECT_ERR_EN defined: adds input port inject_err (1 bit), sampled on the first captured byte of each frame. If that sample was 1, copy 2 transmits its last byte inverted (~data). This exercises the receiver's 2-of-3 vote.
- ONE2THREE_INJECT_ERR_EN undefined: the port is absent, and all copies are identical apart from the ID nibble.

## Test plan
- 60-byte frame, byte 34 = 0xA0:
  - Three 60-cycle en_out bursts separated by 12 idle cycles.
  - Byte 34 reads 0xA1, 0xA2, 0xA3; all other bytes match the input.
  - First en_out 2 cycles after en_in falls.
- 20-byte frame (shorter than ID_OFFSET+1): drop pulses once, no en_out, ready=1 the next cycle.
- 4097-byte frame with ADDR_W=12: DISCARD taken, a single drop pulse after en_in falls, no en_out.
- Second frame started during copy 2: drop pulses on its first byte. Copies 2 and 3 of the first frame are unaffected, with IDs 2 and 3.
- rst pulsed on byte 10 of copy 1: en_out=0 immediately. After release ready=1, and a subsequent 60-byte frame transmits correctly.
- With ONE2THREE_INJECT_ERR_EN and inject_err=1: copy 2 byte 59 equals ~input byte 59. Copies 1 and 3 are correct.
